tdc_tap_encoder: RTL and testbench

TDC_TAP_ENCODER -- requirements
Module: tdc_tap_encoder

---
 rtl/tdc_tap_encoder.sv | 154 +++++++++++++++
 tb/tb_tdc_tap_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_tap_encoder.sv
// Carry-chain TDC front end: it synchronises the thermometer taps, detects hit edges and
// removes bubbles. It then encodes a coarse/fine timestamp behind a 1-deep output register.
module tdc_tap_encoder #(
    parameter int unsigned NUM_TAPS = 64,
    parameter int unsigned COARSE_W = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [NUM_TAPS-1:0]                taps_in,
    output logic                               ts_valid,
    input  logic                               ts_ready,
    output logic [COARSE_W-1:0]                ts_coarse,
    output logic [$clog2(NUM_TAPS+1)-1:0]      ts_fine,
    output logic                               ts_sat,
    output logic [7:0]                         drop_cnt
);

    localparam int unsigned FINE_W = $clog2(NUM_TAPS + 1);

    // two-flop synchroniser with the coarse count of the sampling edge alongside
    logic [NUM_TAPS-1:0] cap1;
    logic [NUM_TAPS-1:0] cap2;
    logic [COARSE_W-1:0] coarse_cnt;
    logic [COARSE_W-1:0] coarse_d1;
    logic [COARSE_W-1:0] coarse_d2;
    logic                cap2_prev;
    logic [2:0]          fill;

    // detect stage
    logic                s2_hit;
    logic [NUM_TAPS-1:0] s2_cap;
    logic [COARSE_W-1:0] s2_coarse;

    // bubble-corrected stage
    logic                s3_hit;
    logic [NUM_TAPS-1:0] s3_corr;
    logic [COARSE_W-1:0] s3_coarse;

    // encoded stage
    logic                s4_valid;
    logic [FINE_W-1:0]   s4_fine;
    logic                s4_sat;
    logic [COARSE_W-1:0] s4_coarse;

    logic                hit_c;
    logic [NUM_TAPS-1:0] corrected_c;
    logic [FINE_W-1:0]   popcnt_c;
    logic                load_c;
    logic                drop_c;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [FINE_W-1:0] popcount(input logic [NUM_TAPS-1:0] v);
        logic [FINE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
            acc = acc + FINE_W'(v[i]);
        end
        return acc;
    endfunction

    // fill tracks when cap1, cap2 and cap2_prev hold real samples after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap1       <= '0;
            cap2       <= '0;
            cap2_prev  <= 1'b0;
            fill       <= '0;
            coarse_cnt <= '0;
            coarse_d1  <= '0;
            coarse_d2  <= '0;
        end else begin
            cap1      <= taps_in;
            cap2      <= cap1;
            cap2_prev <= cap2[0];
            fill      <= {fill[1:0], 1'b1};
            coarse_d1 <= coarse_cnt;
            coarse_d2 <= coarse_d1;
            if (enable) begin
                coarse_cnt <= coarse_cnt + COARSE_W'(1);
            end
        end
    end

    assign hit_c = fill[2] & cap2[0] & ~cap2_prev & enable;

    always_comb begin
        corrected_c           = '0;
        corrected_c[0]        = s2_cap[0];
        for (int i = 1; i < int'(NUM_TAPS) - 1; i++) begin
            corrected_c[i] = maj3(s2_cap[i-1], s2_cap[i], s2_cap[i+1]);
        end
        corrected_c[NUM_TAPS-1] = maj3(s2_cap[NUM_TAPS-2], s2_cap[NUM_TAPS-1],
                                       s2_cap[NUM_TAPS-1]);
    end

    assign popcnt_c = popcount(s3_corr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_hit    <= 1'b0;
            s2_cap    <= '0;
            s2_coarse <= '0;
            s3_hit    <= 1'b0;
            s3_corr   <= '0;
            s3_coarse <= '0;
            s4_valid  <= 1'b0;
            s4_fine   <= '0;
            s4_sat    <= 1'b0;
            s4_coarse <= '0;
        end else begin
            s2_hit    <= hit_c;
            s2_cap    <= cap2;
            s2_coarse <= coarse_d2;
            s3_hit    <= s2_hit;
            s3_corr   <= corrected_c;
            s3_coarse <= s2_coarse;
            s4_valid  <= s3_hit;
            s4_fine   <= popcnt_c;
            s4_sat    <= (popcnt_c == FINE_W'(NUM_TAPS));
            s4_coarse <= s3_coarse;
        end
    end

    // a result lands when the slot is empty or is being drained this cycle
    assign load_c = s4_valid & (~ts_valid | ts_ready);
    assign drop_c = s4_valid & ts_valid & ~ts_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_valid  <= 1'b0;
            ts_coarse <= '0;
            ts_fine   <= '0;
            ts_sat    <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (load_c) begin
                ts_valid  <= 1'b1;
                ts_coarse <= s4_coarse;
                ts_fine   <= s4_fine;
                ts_sat    <= s4_sat;
            end else if (ts_valid && ts_ready) begin
                ts_valid <= 1'b0;
            end
            if (drop_c && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdc_tap_encoder.sv
// Directed bench for tdc_tap_encoder at NUM_TAPS=16, COARSE_W=8 with hand-computed expectations.
module tb_tdc_tap_encoder;

    localparam int unsigned NT = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned FW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NT-1:0] taps_in;
    logic          ts_valid;
    logic          ts_ready;
    logic [CW-1:0] ts_coarse;
    logic [FW-1:0] ts_fine;
    logic          ts_sat;
    logic [7:0]    drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [CW-1:0] mcoarse;
    logic [CW-1:0] c_a;
    logic [CW-1:0] c_hold;

    tdc_tap_encoder #(.NUM_TAPS(NT), .COARSE_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .taps_in   (taps_in),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .ts_coarse (ts_coarse),
        .ts_fine   (ts_fine),
        .ts_sat    (ts_sat),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // free-running reference of the coarse counter, read on the falling edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mcoarse <= '0;
        else if (enable) mcoarse <= mcoarse + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_coarse(input logic [CW-1:0] v);
        int n = 0;
        while (mcoarse != v && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (mcoarse != v) check("wait_coarse_timeout", 32'(mcoarse), 32'(v));
    endtask

    // called just after a falling edge with taps low and the output slot empty
    task automatic send_hit(input string tag, input logic [NT-1:0] pat, input logic [FW-1:0] efine,
                            input logic esat, input logic [CW-1:0] ecoarse);
        taps_in = pat;
        @(posedge clk);
        @(negedge clk);
        taps_in = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_early"}, 32'(ts_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(ts_valid), 32'd1);
        check({tag, "_coarse"}, 32'(ts_coarse), 32'(ecoarse));
        check({tag, "_fine"}, 32'(ts_fine), 32'(efine));
        check({tag, "_sat"}, 32'(ts_sat), 32'(esat));
        ts_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drain"}, 32'(ts_valid), 32'd0);
        ts_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        taps_in  = '0;
        ts_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ts_valid), 32'd0);
        check("rst_coarse", 32'(ts_coarse), 32'd0);
        check("rst_fine", 32'(ts_fine), 32'd0);
        check("rst_sat", 32'(ts_sat), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        wait_coarse(8'h10);
        send_hit("clean", 16'h00FF, 5'd8, 1'b0, 8'h10);
        send_hit("bubble", 16'h00FB, 5'd8, 1'b0, mcoarse);
        send_hit("satur", 16'hFFFF, 5'd16, 1'b1, mcoarse);
        send_hit("one", 16'h0001, 5'd1, 1'b0, mcoarse);
        send_hit("top_bubble", 16'h7FFF, 5'd15, 1'b0, mcoarse);

        // hit while disabled is ignored; counter holds across the gap
        c_hold  = mcoarse;
        enable  = 1'b0;
        taps_in = 16'h00FF;
        @(negedge clk);
        taps_in = '0;
        repeat (8) @(negedge clk);
        check("dis_valid", 32'(ts_valid), 32'd0);
        check("dis_drop", 32'(drop_cnt), 32'd0);
        enable = 1'b1;
        send_hit("reenable", 16'h003F, 5'd6, 1'b0, c_hold);

        wait_coarse(8'h00);
        send_hit("wrap", 16'h0FFF, 5'd12, 1'b0, 8'h00);

        // backpressure: second hit 3 cycles later is dropped, first is held
        c_a     = mcoarse;
        taps_in = 16'h000F;
        @(posedge clk);
        @(negedge clk);
        taps_in = '0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        taps_in = 16'h03FF;
        @(posedge clk);
        @(negedge clk);
        taps_in = '0;
        repeat (3) @(negedge clk);
        check("bp_first_valid", 32'(ts_valid), 32'd1);
        check("bp_first_fine", 32'(ts_fine), 32'd4);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", 32'(ts_valid), 32'd1);
        check("bp_hold_coarse", 32'(ts_coarse), 32'(c_a));
        check("bp_hold_fine", 32'(ts_fine), 32'd4);
        check("bp_drop", 32'(drop_cnt), 32'd1);
        ts_ready = 1'b1;
        @(negedge clk);
        check("bp_drain", 32'(ts_valid), 32'd0);
        ts_ready = 1'b0;

        // a rise every 2 cycles with no consumer: drop counter must saturate
        for (int i = 0; i < 300; i++) begin
            taps_in = 16'h0001;
            @(negedge clk);
            taps_in = '0;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("dsat_drop", 32'(drop_cnt), 32'd255);
        check("dsat_valid", 32'(ts_valid), 32'd1);
        check("dsat_fine", 32'(ts_fine), 32'd1);
        ts_ready = 1'b1;
        @(negedge clk);
        check("dsat_drain", 32'(ts_valid), 32'd0);
        ts_ready = 1'b0;

        // reset 2 cycles after a hit's sampling edge; taps high at release
        taps_in = 16'h000F;
        @(posedge clk);
        @(negedge clk);
        taps_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        taps_in = 16'hFFFF;
        @(negedge clk);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        taps_in = '0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", 32'(ts_valid), 32'd0);
        check("post_rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        send_hit("post_rst", 16'h00FF, 5'd8, 1'b0, 8'd4);
        check("final_drop", 32'(drop_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
